ppm_axil_regfile: RTL and testbench

PPM_AXIL_REGFILE -- requirements
Module: ppm_axil_regfile

---
 rtl/ppm_regs_pkg.sv | 30 +++
 rtl/ppm_axil_if.sv | 133 +++++++++++++
 rtl/ppm_axil_regfile.sv | 187 ++++++++++++++++++
 tb/tb_ppm_axil_regfile.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_regs_pkg.sv
// Shared register indices, STATUS layout and AXI response codes for the PPM register file.
package ppm_regs_pkg;

  localparam int IDX_CTRL   = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_DET0   = 2;

  localparam int CTRL_CLR_BIT    = 31;
  localparam int STATUS_FCNT_LSB = 0;
  localparam int STATUS_FCNT_MSB = 15;
  localparam int STATUS_OVR_BIT  = 16;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ppm_axil_if.sv
// AXI4-Lite slave handshake: AW and W captured independently, one write and one read in flight.
// Register decode and responses come from the parent through the wr_*/rd_* side ports.
module ppm_axil_if
  import ppm_regs_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  axi_resp_e           wr_resp_i,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  axi_resp_e           rd_resp_i
);

  logic                aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  axi_resp_e           bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  axi_resp_e           rresp_q, rresp_d;

  // Readies are held low during reset so nothing is accepted until the cycle after release.
  assign awready_o = !rst_i && !aw_held_q && !bvalid_q;
  assign wready_o  = !rst_i && !w_held_q && !bvalid_q;
  assign arready_o = !rst_i && !rvalid_q;

  assign wr_en_o   = aw_held_q && w_held_q && !bvalid_q;
  assign wr_addr_o = awaddr_q;
  assign wr_data_o = wdata_q;
  assign wr_strb_o = wstrb_q;
  assign rd_en_o   = arvalid_i && arready_o;
  assign rd_addr_o = araddr_i;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (awvalid_i && awready_o) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (wvalid_i && wready_o) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (wr_en_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp_i;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end

    if (rd_en_o) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_i;
      rresp_d  = rd_resp_i;
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/ppm_axil_regfile.sv
// PPM register file: CTRL, STATUS, detector snapshots and generator widths behind AXI4-Lite.
// Define PPM_REGS_WSTRB_EN to honour per-byte write strobes; otherwise full words are written.
module ppm_axil_regfile
  import ppm_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_CH             = 6,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            det_frame_i,
  input  logic [32*NUM_CH-1:0]            det_ch_i,
  output logic [31:0]                     ctrl_o,
  output logic [32*NUM_CH-1:0]            gen_ch_o
);

  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int GEN_BASE = IDX_DET0 + NUM_CH;

  logic                            wr_en, rd_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr, rd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  axi_resp_e                       wr_resp, rd_resp;
  logic [IDX_W-1:0]                wr_idx, rd_idx;
  logic [31:0]                     wmask;
  logic                            det_rd, clr;
  logic                            unused_addr_lsbs;

  logic [31:0]             ctrl_q, ctrl_d;
  logic [15:0]             fcnt_q, fcnt_d;
  logic                    ovr_q, ovr_d;
  logic                    unread_q, unread_d;
  logic [NUM_CH-1:0][31:0] det_q, det_d;
  logic [NUM_CH-1:0][31:0] gen_q, gen_d;

  ppm_axil_if #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_if (
    .clk_i     (s00_axi_aclk),
    .rst_i     (s00_axi_areset),
    .awaddr_i  (s00_axi_awaddr),
    .awvalid_i (s00_axi_awvalid),
    .awready_o (s00_axi_awready),
    .wdata_i   (s00_axi_wdata),
    .wstrb_i   (s00_axi_wstrb),
    .wvalid_i  (s00_axi_wvalid),
    .wready_o  (s00_axi_wready),
    .bresp_o   (s00_axi_bresp),
    .bvalid_o  (s00_axi_bvalid),
    .bready_i  (s00_axi_bready),
    .araddr_i  (s00_axi_araddr),
    .arvalid_i (s00_axi_arvalid),
    .arready_o (s00_axi_arready),
    .rdata_o   (s00_axi_rdata),
    .rresp_o   (s00_axi_rresp),
    .rvalid_o  (s00_axi_rvalid),
    .rready_i  (s00_axi_rready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb),
    .wr_resp_i (wr_resp),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .rd_resp_i (rd_resp)
  );

  assign wr_idx           = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx           = rd_addr[C_S_AXI_ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = &{1'b0, wr_addr[1:0], rd_addr[1:0]};

`ifdef PPM_REGS_WSTRB_EN
  assign wmask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
`else
  logic unused_strb;
  assign wmask       = '1;
  assign unused_strb = &{1'b0, wr_strb};
`endif

  always_comb begin
    ctrl_d   = ctrl_q;
    fcnt_d   = fcnt_q;
    ovr_d    = ovr_q;
    unread_d = unread_q;
    det_d    = det_q;
    gen_d    = gen_q;
    wr_resp  = RESP_SLVERR;
    rd_resp  = RESP_SLVERR;
    rd_data  = '0;
    det_rd   = 1'b0;
    clr      = 1'b0;

    // The clear bit is a command, never stored, so CTRL[31] always reads 0.
    if (wr_idx == IDX_W'(IDX_CTRL)) begin
      wr_resp = RESP_OKAY;
      if (wr_en) begin
        ctrl_d               = (ctrl_q & ~wmask) | (wr_data & wmask);
        clr                  = ctrl_d[CTRL_CLR_BIT];
        ctrl_d[CTRL_CLR_BIT] = 1'b0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_idx == IDX_W'(GEN_BASE + k)) begin
        wr_resp = RESP_OKAY;
        if (wr_en) gen_d[k] = (gen_q[k] & ~wmask) | (wr_data & wmask);
      end
    end

    if (rd_idx == IDX_W'(IDX_CTRL)) begin
      rd_resp = RESP_OKAY;
      rd_data = ctrl_q;
    end
    if (rd_idx == IDX_W'(IDX_STATUS)) begin
      rd_resp                                  = RESP_OKAY;
      rd_data[STATUS_FCNT_MSB:STATUS_FCNT_LSB] = fcnt_q;
      rd_data[STATUS_OVR_BIT]                  = ovr_q;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_idx == IDX_W'(IDX_DET0 + k)) begin
        rd_resp = RESP_OKAY;
        rd_data = det_q[k];
        det_rd  = rd_en;
      end
      if (rd_idx == IDX_W'(GEN_BASE + k)) begin
        rd_resp = RESP_OKAY;
        rd_data = gen_q[k];
      end
    end

    if (clr) begin
      fcnt_d = '0;
      ovr_d  = 1'b0;
    end
    // A read landing with a new frame returns the old snapshot and counts as consuming it.
    if (det_frame_i) begin
      det_d    = det_ch_i;
      fcnt_d   = fcnt_d + 16'd1;
      ovr_d    = ovr_d | (unread_q & ~det_rd & ~clr);
      unread_d = 1'b1;
    end else if (det_rd) begin
      unread_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ctrl_q   <= '0;
      fcnt_q   <= '0;
      ovr_q    <= 1'b0;
      unread_q <= 1'b0;
      det_q    <= '0;
      gen_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      fcnt_q   <= fcnt_d;
      ovr_q    <= ovr_d;
      unread_q <= unread_d;
      det_q    <= det_d;
      gen_q    <= gen_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign gen_ch_o = gen_q;

endmodule

// File: tb/tb_ppm_axil_regfile.sv
// Directed self-checking bench for ppm_axil_regfile (NUM_CH=6, 7-bit byte addresses).
module tb_ppm_axil_regfile;

  localparam int NCH = 6;
  localparam int AW  = 7;

  localparam logic [AW-1:0] A_CTRL   = 7'h00;
  localparam logic [AW-1:0] A_STATUS = 7'h04;
  localparam logic [AW-1:0] A_DET0   = 7'h08;
  localparam logic [AW-1:0] A_DET5   = 7'h1C;
  localparam logic [AW-1:0] A_GEN0   = 7'h20;
  localparam logic [AW-1:0] A_GEN1   = 7'h24;
  localparam logic [AW-1:0] A_UNMAP  = 7'h38;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ctrl;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic det_frame;
  logic [32*NCH-1:0] det_ch, gen_ch;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ppm_axil_regfile #(
    .C_S_AXI_DATA_WIDTH (32),
    .NUM_CH             (NCH),
    .C_S_AXI_ADDR_WIDTH (AW)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .det_frame_i     (det_frame),
    .det_ch_i        (det_ch),
    .ctrl_o          (ctrl),
    .gen_ch_o        (gen_ch)
  );

  function automatic logic [32*NCH-1:0] pat(input logic [31:0] base);
    logic [32*NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  // All bus tasks start and end just after a falling edge.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    n_chk++;
    if (!bvalid) begin n_fail++; $display("FAIL write_timeout addr=%h: bvalid=0, required 1", a); end
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    n_chk++;
    if (!rvalid) begin n_fail++; $display("FAIL read_timeout addr=%h: rvalid=0, required 1", a); end
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse_frame(input logic [31:0] base);
    det_ch = pat(base); det_frame = 1'b1;
    @(negedge clk);
    det_frame = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready: got %b, required 0", awready); end
    n_chk++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b, required 0", wready); end
    n_chk++; if (arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b, required 0", arready); end
    n_chk++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_valids: got b=%b r=%b, required 0 0", bvalid, rvalid); end
    n_chk++; if (bresp !== 2'b00 || rresp !== 2'b00) begin n_fail++; $display("FAIL rst_resps: got b=%b r=%b, required 00 00", bresp, rresp); end
    n_chk++; if (ctrl !== 32'h0 || gen_ch !== '0) begin n_fail++; $display("FAIL rst_regs: got ctrl=%h gen=%h, required 0", ctrl, gen_ch); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got aw=%b w=%b ar=%b, required 1 1 1", awready, wready, arready); end
  endtask

  task automatic test_gen_rw();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(A_GEN0, 32'h1, 4'hF, r);
    n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL gen0_wr_resp: got %b, required 00", r); end
    axi_write(A_GEN1, 32'h2, 4'hF, r);
    n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL gen1_wr_resp: got %b, required 00", r); end
    axi_read(A_GEN0, d, r);
    n_chk++; if (d !== 32'h1 || r !== 2'b00) begin n_fail++; $display("FAIL gen0_rd: got %h/%b, required 00000001/00", d, r); end
    axi_read(A_GEN1, d, r);
    n_chk++; if (d !== 32'h2 || r !== 2'b00) begin n_fail++; $display("FAIL gen1_rd: got %h/%b, required 00000002/00", d, r); end
    n_chk++; if (gen_ch[63:0] !== 64'h00000002_00000001) begin n_fail++; $display("FAIL gen_ch_o: got %h, required 0000000200000001", gen_ch[63:0]); end
  endtask

  task automatic test_aw_before_w();
    awaddr = A_CTRL; awvalid = 1'b1;
    n_chk++; if (awready !== 1'b1) begin n_fail++; $display("FAIL awfirst_awready: got %b, required 1", awready); end
    @(negedge clk); awvalid = 1'b0;
    n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL awfirst_held: awready got %b, required 0", awready); end
    @(negedge clk);
    n_chk++; if (bvalid !== 1'b0 || ctrl !== 32'h0) begin n_fail++; $display("FAIL awfirst_nocommit: got bvalid=%b ctrl=%h, required 0 0", bvalid, ctrl); end
    @(negedge clk);
    wdata = 32'hA5; wstrb = 4'hF; wvalid = 1'b1;
    n_chk++; if (wready !== 1'b1) begin n_fail++; $display("FAIL awfirst_wready: got %b, required 1", wready); end
    @(negedge clk); wvalid = 1'b0;
    n_chk++; if (bvalid !== 1'b0 || ctrl !== 32'h0) begin n_fail++; $display("FAIL awfirst_early: got bvalid=%b ctrl=%h, required 0 0", bvalid, ctrl); end
    @(negedge clk);
    n_chk++; if (bvalid !== 1'b1 || ctrl !== 32'hA5 || bresp !== 2'b00) begin n_fail++; $display("FAIL awfirst_commit: got bvalid=%b ctrl=%h bresp=%b, required 1 a5 00", bvalid, ctrl, bresp); end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    n_chk++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL awfirst_bdone: bvalid got %b, required 0", bvalid); end
  endtask

  task automatic test_frames();
    logic [1:0] r;
    logic [31:0] d;
    pulse_frame(32'h100);
    pulse_frame(32'h200);
    axi_read(A_STATUS, d, r);
    n_chk++; if (d !== 32'h0001_0002 || r !== 2'b00) begin n_fail++; $display("FAIL status_2frames: got %h/%b, required 00010002/00", d, r); end
    axi_read(A_DET0, d, r);
    n_chk++; if (d !== 32'h200) begin n_fail++; $display("FAIL det0_snap: got %h, required 00000200", d); end
    axi_read(A_DET5, d, r);
    n_chk++; if (d !== 32'h205) begin n_fail++; $display("FAIL det5_snap: got %h, required 00000205", d); end
    axi_write(A_CTRL, 32'h8000_0000, 4'hF, r);
    n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL clr_resp: got %b, required 00", r); end
    axi_read(A_STATUS, d, r);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL status_cleared: got %h, required 00000000", d); end
    axi_read(A_CTRL, d, r);
    n_chk++; if (d !== 32'h0 || ctrl !== 32'h0) begin n_fail++; $display("FAIL ctrl_selfclear: got rd=%h ctrl_o=%h, required 0 0", d, ctrl); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] r;
    logic [31:0] d;
    pulse_frame(32'h300);
    awaddr = A_CTRL; wdata = 32'h8000_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    det_ch = pat(32'h400); det_frame = 1'b1;
    @(negedge clk);
    det_frame = 1'b0;
    n_chk++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL clr_frame_bvalid: got %b, required 1", bvalid); end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    axi_read(A_STATUS, d, r);
    n_chk++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL clr_with_frame: got %h, required 00000001", d); end
    araddr = A_DET0; arvalid = 1'b1;
    det_ch = pat(32'h500); det_frame = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; det_frame = 1'b0; rready = 1'b1;
    n_chk++; if (rvalid !== 1'b1 || rdata !== 32'h400) begin n_fail++; $display("FAIL rd_with_frame: got rvalid=%b rdata=%h, required 1 00000400", rvalid, rdata); end
    @(negedge clk); rready = 1'b0;
    pulse_frame(32'h600);
    axi_read(A_STATUS, d, r);
    n_chk++; if (d !== 32'h0001_0003) begin n_fail++; $display("FAIL unread_kept: got %h, required 00010003", d); end
  endtask

  task automatic test_errors();
    logic [1:0] r;
    logic [31:0] d;
    axi_read(A_UNMAP, d, r);
    n_chk++; if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h/%b, required 00000000/10", d, r); end
    axi_write(A_DET0, 32'h1234_5678, 4'hF, r);
    n_chk++; if (r !== 2'b10) begin n_fail++; $display("FAIL det_wr_resp: got %b, required 10", r); end
    axi_read(A_DET0, d, r);
    n_chk++; if (d !== 32'h600 || r !== 2'b00) begin n_fail++; $display("FAIL det_unchanged: got %h/%b, required 00000600/00", d, r); end
    axi_write(A_STATUS, 32'hFFFF_FFFF, 4'hF, r);
    n_chk++; if (r !== 2'b10) begin n_fail++; $display("FAIL status_wr_resp: got %b, required 10", r); end
    axi_read(A_STATUS, d, r);
    n_chk++; if (d !== 32'h0001_0003) begin n_fail++; $display("FAIL status_unchanged: got %h, required 00010003", d); end
    axi_write(A_UNMAP, 32'hDEAD_BEEF, 4'hF, r);
    n_chk++; if (r !== 2'b10) begin n_fail++; $display("FAIL unmapped_wr: got %b, required 10", r); end
  endtask

  task automatic test_wstrb();
    logic [1:0] r;
    logic [31:0] d;
    logic [31:0] exp;
`ifdef PPM_REGS_WSTRB_EN
    exp = 32'h0000_FF00;
`else
    exp = 32'hFFFF_FFFF;
`endif
    axi_write(A_GEN0, 32'h0, 4'hF, r);
    axi_write(A_GEN0, 32'hFFFF_FFFF, 4'b0010, r);
    n_chk++; if (r !== 2'b00) begin n_fail++; $display("FAIL strb_resp: got %b, required 00", r); end
    axi_read(A_GEN0, d, r);
    n_chk++; if (d !== exp || gen_ch[31:0] !== exp) begin n_fail++; $display("FAIL strb_data: got rd=%h gen=%h, required %h", d, gen_ch[31:0], exp); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r;
    logic [31:0] d;
    awaddr = A_GEN1; wdata = 32'hCAFE_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin n_fail++; $display("FAIL stall_cycle%0d: got bvalid=%b awready=%b wready=%b, required 1 0 0", i, bvalid, awready, wready); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    n_chk++; if (bvalid !== 1'b0 || awready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got bvalid=%b awready=%b, required 0 1", bvalid, awready); end
    axi_read(A_GEN1, d, r);
    n_chk++; if (d !== 32'hCAFE_0001 || gen_ch[63:32] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stall_data: got rd=%h gen=%h, required cafe0001", d, gen_ch[63:32]); end
  endtask

  task automatic test_reset_mid();
    awaddr = A_GEN1; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL mid_aw_held: awready got %b, required 0", awready); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (awready !== 1'b0 || bvalid !== 1'b0 || gen_ch !== '0 || ctrl !== 32'h0) begin n_fail++; $display("FAIL mid_in_reset: got awready=%b bvalid=%b gen=%h ctrl=%h, required 0 0 0 0", awready, bvalid, gen_ch, ctrl); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got awready=%b wready=%b bvalid=%b, required 1 1 0", awready, wready, bvalid); end
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    n_chk++; if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) begin n_fail++; $display("FAIL mid_w_only: got bvalid=%b wready=%b awready=%b, required 0 0 1", bvalid, wready, awready); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; det_frame = 1'b0; det_ch = '0;
    @(negedge clk);
    test_reset();
    test_gen_rw();
    test_aw_before_w();
    test_frames();
    test_simultaneous();
    test_errors();
    test_wstrb();
    test_bready_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
